uart_byte_rx: RTL and testbench

//  - 8N1 UART byte receiver; downstream partner of uart_byte_tx (same board, same clock domain).
//  - Samples the serial line, rebuilds one byte per frame, flags good bytes and framing errors.
//  - Used for loopback checks of the transmitter and as the PL command input path.

---
 rtl/uart_byte_rx.sv | 206 ++++++++++++++++++++
 tb/tb_uart_byte_rx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// ---------------------------------------------------------------------------
// uart_byte_rx -- 8N1 UART byte receiver
//
// Rebuilds one byte per serial frame from an asynchronous, idle-high line,
// publishes good bytes and flags frames whose stop bit is sampled low.
// Intended as the downstream partner of uart_byte_tx in the same clock domain.
//
// Parameters
//   CLK_FREQ  system clock frequency in Hz
//   BAUD      line rate in bit/s; CLK_FREQ/BAUD clocks per bit
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   uart_rx    in   serial line, idle high, asynchronous to clk
//   rx_data    out  [7:0] last good byte, held until the next good byte
//   rx_done    out  one-cycle pulse, rx_data has just been updated
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   rx_busy    out  high from start-edge detect until return to IDLE
//   led        out  toggles on every rx_done
//
// Build option
//   UART_RX_MAJORITY_EN  when defined, every sample point takes a 2-of-3 vote
//                        over the synchronised line at cnt-1, cnt and cnt+1,
//                        so every decision lands one clock later and a
//                        single-cycle glitch is rejected. When undefined, one
//                        sample is taken at the sample point.
//
// Handshake: rx_done and frame_err are single-cycle strobes with no ready
// back-pressure; rx_data is valid from the rx_done cycle until the next one.
// ---------------------------------------------------------------------------
module uart_byte_rx #(
   parameter int CLK_FREQ = 125_000_000,
   parameter int BAUD     = 115_200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       frame_err,
   output logic       rx_busy,
   output logic       led
);

   localparam int BIT_CNT  = CLK_FREQ / BAUD;
   localparam int HALF_CNT = BIT_CNT / 2;
   localparam int CNT_W    = $clog2(BIT_CNT);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_CNT);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_done_q, rx_done_d;
   logic             frame_err_q, frame_err_d;
   logic             led_q, led_d;

   // Two-flop synchroniser (rx_meta_q, rx_s_q) plus one delay flop for edge detect.
   logic rx_meta_q, rx_s_q, rx_d_q;
   logic start_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_d_q    <= 1'b1;
      end else begin
         rx_meta_q <= uart_rx;
         rx_s_q    <= rx_meta_q;
         rx_d_q    <= rx_s_q;
      end
   end

   assign start_edge = rx_d_q & ~rx_s_q;

   // Nominal mid-bit instant: half a bit after the start edge, then every
   // full bit (the counter wraps at CNT_LAST, so no explicit reload is needed).
   logic sample_pt;
   assign sample_pt = ((state_q == START) && (cnt_q == CNT_HALF)) ||
                      (((state_q == DATA) || (state_q == STOP)) && (cnt_q == CNT_LAST));

   logic decide;   // act on a sampled bit this cycle
   logic bit_val;  // value of that sampled bit

`ifdef UART_RX_MAJORITY_EN
   // hist_q[0] holds rx_s at the sample point, hist_q[1] the cycle before;
   // rx_s_q is the cycle after, so the vote is taken one clock late.
   logic [1:0] hist_q;
   logic       pt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= 2'b11;
         pt_q   <= 1'b0;
      end else begin
         hist_q <= {hist_q[0], rx_s_q};
         pt_q   <= sample_pt;
      end
   end

   assign decide  = pt_q;
   assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
   assign decide  = sample_pt;
   assign bit_val = rx_s_q;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         rx_data_q   <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         led_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         rx_data_q   <= rx_data_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
         led_q       <= led_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      rx_data_d   = rx_data_q;
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;
      led_d       = led_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start_edge) state_d = START;
         end
         START: begin
            if (decide) begin
               if (bit_val) begin
                  state_d = IDLE;              // glitch, not a real start bit
               end else begin
                  state_d   = DATA;
                  cnt_d     = '0;
                  bit_idx_d = '0;
               end
            end
         end
         DATA: begin
            if (decide) begin
               shreg_d   = {bit_val, shreg_q[7:1]};   // LSB arrives first
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            // Leave at mid stop bit so a back-to-back start edge is still seen.
            if (decide) begin
               if (bit_val) begin
                  rx_data_d = shreg_q;
                  rx_done_d = 1'b1;
                  led_d     = ~led_q;
                  state_d   = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
            end
         end
         BREAK: begin
            // Hold here while the line stays low so a break gives one frame_err.
            cnt_d = '0;
            if (rx_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx_data   = rx_data_q;
   assign rx_done   = rx_done_q;
   assign frame_err = frame_err_q;
   assign rx_busy   = (state_q != IDLE);
   assign led       = led_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_byte_rx -- self-checking bench for uart_byte_rx
//
// A fast instance (12.5 Mbaud at 125 MHz, 10 clocks per bit) takes directed
// frames and a randomized frame stream; a second instance at the default
// 115200 baud takes one frame. The reference model works per frame: a frame
// with a high stop bit yields rx_done with its byte and a toggled led, a low
// stop bit (or a held-low break) yields one frame_err with rx_data unchanged.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_byte_rx;

   localparam int CLK_FREQ = 125_000_000;
   localparam int BAUD     = 12_500_000;
   localparam int BIT      = CLK_FREQ / BAUD;
   localparam int HALF     = BIT / 2;
   localparam int BIT_D    = CLK_FREQ / 115_200;
   localparam int HALF_D   = BIT_D / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif
   // rx_done follows the start-bit falling edge by 3 + 9*BIT + HALF clocks,
   // +/-1, plus one clock when majority voting is built in.
   localparam int LAT_LO   = 2 + 9 * BIT + HALF;
   localparam int LAT_HI   = 4 + 9 * BIT + HALF + MAJ;
   localparam int LAT_LO_D = 2 + 9 * BIT_D + HALF_D;
   localparam int LAT_HI_D = 4 + 9 * BIT_D + HALF_D + MAJ;

   localparam logic [1:0] KIND_DONE = 2'd1;
   localparam logic [1:0] KIND_ERR  = 2'd2;
   localparam int EW = 43;   // {t_start[31:0], led, kind[1:0], data[7:0]}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;

   always #4 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUTs ----------------
   logic       uart_rx, uart_rx2;
   logic [7:0] rx_data, rx_data2;
   logic       rx_done, rx_done2;
   logic       frame_err, frame_err2;
   logic       rx_busy, rx_busy2;
   logic       led, led2;

   uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart_rx   (uart_rx),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .frame_err (frame_err),
      .rx_busy   (rx_busy),
      .led       (led)
   );

   uart_byte_rx dut_def (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart_rx   (uart_rx2),
      .rx_data   (rx_data2),
      .rx_done   (rx_done2),
      .frame_err (frame_err2),
      .rx_busy   (rx_busy2),
      .led       (led2)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   logic [7:0]    model_last = 8'h00;
   logic          model_led  = 1'b0;

   task automatic model_frame(input logic [7:0] seen, input logic stop_ok);
      if (stop_ok) begin
         model_last = seen;
         model_led  = ~model_led;
         exp_q.push_back({32'(cyc), model_led, KIND_DONE, seen});
      end else begin
         exp_q.push_back({32'(cyc), model_led, KIND_ERR, model_last});
      end
   endtask

   logic [1:0]    mon_kind;
   logic [EW-1:0] mon_e;
   logic          prev_pulse = 1'b0;
   int            lat;

   always @(posedge clk) begin
      #1;
      if (rst_n && (rx_done || frame_err)) begin
         mon_kind = {frame_err, rx_done};
         check("pulse_exclusive", 32'(rx_done & frame_err), 32'd0);
         check("pulse_single_cycle", 32'(prev_pulse), 32'd0);
         if (exp_q.size() == 0) begin
            check("spurious_event", 32'(mon_kind), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("event_kind", 32'(mon_kind), 32'(mon_e[9:8]));
            check("event_rx_data", 32'(rx_data), 32'(mon_e[7:0]));
            check("event_led", 32'(led), 32'(mon_e[10]));
            if (rx_done) begin
               lat = cyc - int'(mon_e[42:11]);
               check("done_latency_window", 32'(lat >= LAT_LO && lat <= LAT_HI), 32'd1);
            end
         end
      end
      prev_pulse = rst_n & (rx_done | frame_err);
   end

   // Default-rate instance: simple event recorder.
   int         d2_done_cnt = 0;
   int         d2_err_cnt  = 0;
   logic [7:0] d2_data     = 8'h00;
   int         d2_t        = 0;

   always @(posedge clk) begin
      #1;
      if (rst_n && rx_done2) begin
         d2_done_cnt++;
         d2_data = rx_data2;
         d2_t    = cyc;
      end
      if (rst_n && frame_err2) d2_err_cnt++;
   end

   // ---------------- driver tasks (all called at a negedge) ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic mid_reset();
      rst_n   = 1'b0;
      uart_rx = 1'b1;
      idle(2);
      check("abort_rx_data", 32'(rx_data), 32'h00);
      check("abort_rx_done", 32'(rx_done), 32'd0);
      check("abort_frame_err", 32'(frame_err), 32'd0);
      check("abort_rx_busy", 32'(rx_busy), 32'd0);
      check("abort_led", 32'(led), 32'd0);
      model_last = 8'h00;
      model_led  = 1'b0;
      rst_n      = 1'b1;
      idle(2 * BIT);
   endtask

   // glitch_bit >= 0: one-clock inverted pulse on that data bit, placed on the
   // clock edge whose line value the synchroniser delivers at the sample point.
   // abort_bit >= 0: reset pulse in the middle of that data bit.
   task automatic send_frame(input logic [7:0] data, input logic stop_ok,
                             input int glitch_bit, input int abort_bit);
      logic [9:0] frame;
      logic [7:0] seen;
      frame = {stop_ok, data, 1'b0};
      seen  = data;
      if (glitch_bit >= 0 && MAJ == 0) seen[glitch_bit] = ~seen[glitch_bit];
      if (abort_bit < 0) model_frame(seen, stop_ok);
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < BIT; c++) begin
            uart_rx = (glitch_bit >= 0 && i == glitch_bit + 1 && c == HALF + 1) ? ~frame[i] : frame[i];
            if (abort_bit >= 0 && i == abort_bit + 1 && c == HALF) begin
               mid_reset();
               return;
            end
            if (i == 5 && c == 0) check("rx_busy_mid_frame", 32'(rx_busy), 32'd1);
            @(negedge clk);
         end
      end
      uart_rx = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   int         gap;
   logic [7:0] rnd_byte;
   logic       rnd_stop;
   logic [9:0] frame2;
   int         t2;

   initial begin
      rst_n    = 1'b0;
      uart_rx  = 1'b1;
      uart_rx2 = 1'b1;
      idle(3);
      check("reset_rx_data", 32'(rx_data), 32'h00);
      check("reset_rx_done", 32'(rx_done), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      check("reset_rx_busy", 32'(rx_busy), 32'd0);
      check("reset_led", 32'(led), 32'd0);
      check("reset_def_rx_data", 32'(rx_data2), 32'h00);
      rst_n = 1'b1;
      idle(2 * BIT);

      // single good byte
      send_frame(8'h6C, 1'b1, -1, -1);
      idle(BIT);
      check("single_rx_data", 32'(rx_data), 32'h6C);
      check("single_led", 32'(led), 32'd1);

      // back-to-back frames, no idle gap
      send_frame(8'h6C, 1'b1, -1, -1);
      send_frame(8'hAA, 1'b1, -1, -1);
      idle(BIT);
      check("b2b_rx_data", 32'(rx_data), 32'hAA);
      check("b2b_led", 32'(led), 32'(model_led));

      // stop bit low, line high afterwards
      send_frame(8'h55, 1'b0, -1, -1);
      idle(2 * BIT);
      check("framing_keeps_rx_data", 32'(rx_data), 32'hAA);
      check("framing_back_idle", 32'(rx_busy), 32'd0);

      // break: line held low well past a whole frame, then a normal byte
      model_frame(8'h00, 1'b0);
      uart_rx = 1'b0;
      idle(15 * BIT);
      uart_rx = 1'b1;
      idle(2 * BIT);
      check("break_back_idle", 32'(rx_busy), 32'd0);
      send_frame(8'h0F, 1'b1, -1, -1);
      idle(BIT);
      check("after_break_rx_data", 32'(rx_data), 32'h0F);

      // false start: low pulse shorter than half a bit
      uart_rx = 1'b0;
      idle(HALF - 2);
      uart_rx = 1'b1;
      idle(2);
      check("false_start_busy_high", 32'(rx_busy), 32'd1);
      idle(2 * BIT);
      check("false_start_busy_low", 32'(rx_busy), 32'd0);

      // single-clock glitch on data bit 2 of 0x00
      send_frame(8'h00, 1'b1, 2, -1);
      idle(BIT);
      check("glitch_rx_data", 32'(rx_data), 32'(MAJ ? 8'h00 : 8'h04));

      // reset during bit 4 of 0xA5, then 0x3C
      send_frame(8'hA5, 1'b1, -1, 4);
      send_frame(8'h3C, 1'b1, -1, -1);
      idle(BIT);
      check("post_abort_rx_data", 32'(rx_data), 32'h3C);
      check("post_abort_led", 32'(led), 32'd1);

      // randomized frame stream
      for (int n = 0; n < 40; n++) begin
         rnd_byte = 8'($urandom_range(0, 255));
         rnd_stop = ($urandom_range(0, 7) != 0);
         send_frame(rnd_byte, rnd_stop, -1, -1);
         // after a bad stop the line must go high before the next start
         gap = rnd_stop ? $urandom_range(0, 2 * BIT) : $urandom_range(BIT, 2 * BIT);
         idle(gap);
      end
      idle(2 * BIT);
      check("random_final_rx_data", 32'(rx_data), 32'(model_last));
      check("missing_events", 32'(exp_q.size()), 32'd0);

      // one frame at the default rate
      frame2 = {1'b1, 8'h6C, 1'b0};
      t2     = cyc;
      for (int i = 0; i < 10; i++) begin
         uart_rx2 = frame2[i];
         idle(BIT_D);
      end
      uart_rx2 = 1'b1;
      idle(BIT_D);
      check("def_done_count", 32'(d2_done_cnt), 32'd1);
      check("def_rx_data", 32'(d2_data), 32'h6C);
      check("def_led", 32'(led2), 32'd1);
      check("def_frame_err_count", 32'(d2_err_cnt), 32'd0);
      check("def_latency_window", 32'((d2_t - t2) >= LAT_LO_D && (d2_t - t2) <= LAT_HI_D), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
